// File: rtl/crc_frame_ctrl_if.sv
// rtl/crc_frame_ctrl_if.sv - UART byte, TX/RX block and CRC-unit signal bundle of crc_frame_ctrl
// slave is the controller side; master is the surrounding UART/AES/CRC environment.
interface crc_frame_ctrl_if;
  logic         urx_valid;
  logic [7:0]   urx_data;
  logic [111:0] rx_block;
  logic         rx_frame_valid;
  logic         rx_crc_err;
  logic         tx_start;
  logic [111:0] tx_block;
  logic         tx_busy;
  logic         utx_valid;
  logic [7:0]   utx_data;
  logic         utx_ready;
  logic [111:0] crc_data;
  logic         crc_en;
  logic [15:0]  crc_in;

  modport slave (
    input  urx_valid, urx_data, tx_start, tx_block, utx_ready, crc_in,
    output rx_block, rx_frame_valid, rx_crc_err, tx_busy, utx_valid, utx_data,
           crc_data, crc_en
  );

  modport master (
    output urx_valid, urx_data, tx_start, tx_block, utx_ready, crc_in,
    input  rx_block, rx_frame_valid, rx_crc_err, tx_busy, utx_valid, utx_data,
           crc_data, crc_en
  );
endinterface

// File: rtl/crc_frame_ctrl.sv
// rtl/crc_frame_ctrl.sv - RX/TX 16-byte frame controller and arbiter for a shared CRC-16 unit
// Optional RX inter-byte timeout is enabled by defining CRC_CTRL_TIMEOUT_EN.
module crc_frame_ctrl
`ifdef CRC_CTRL_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 100000)
`endif
(
  input  logic            clk,
  input  logic            rst_n,
  crc_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {TX_IDLE, TX_CRC, TX_SEND} tx_state_t;

  logic [3:0]   r_rx_cnt;
  logic [111:0] r_rx_pay;
  logic [7:0]   r_rx_crc_hi;
  logic [111:0] r_chk_pay;
  logic [15:0]  r_chk_crc;
  logic         r_rx_req;
  logic [111:0] r_rx_block;
  logic         r_rx_frame_valid;
  logic         r_rx_crc_err;

  tx_state_t    r_tx_state;
  tx_state_t    w_tx_state_nxt;
  logic [111:0] r_tx_pay;
  logic [15:0]  r_tx_crc;
  logic [3:0]   r_tx_idx;
  logic         r_tx_req;

  logic         w_grant_rx;
  logic         w_grant_tx;
  logic         w_timeout;
  logic         w_rx_load;
  logic         w_crc_match;
  logic         w_tx_accept;
  logic         w_tx_hs;
  logic [127:0] w_tx_frame;
  logic [6:0]   w_tx_msb;

`ifdef CRC_CTRL_TIMEOUT_EN
  logic [31:0] r_idle_cnt;

  assign w_timeout = (r_idle_cnt == TIMEOUT_CYCLES);

  // Saturates at the limit so an idle link with no partial frame stays quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (bus.urx_valid) begin
      r_idle_cnt <= '0;
    end else if (!w_timeout) begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_grant_rx    = r_rx_req;
  assign w_grant_tx    = r_tx_req && !r_rx_req;
  assign bus.crc_en    = w_grant_rx || w_grant_tx;
  assign bus.crc_data  = w_grant_rx ? r_chk_pay : (w_grant_tx ? r_tx_pay : '0);

  assign w_rx_load   = bus.urx_valid && (r_rx_cnt == 4'd15);
  assign w_crc_match = (bus.crc_in == r_chk_crc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_cnt         <= '0;
      r_rx_pay         <= '0;
      r_rx_crc_hi      <= '0;
      r_chk_pay        <= '0;
      r_chk_crc        <= '0;
      r_rx_req         <= 1'b0;
      r_rx_block       <= '0;
      r_rx_frame_valid <= 1'b0;
      r_rx_crc_err     <= 1'b0;
    end else begin
      if (bus.urx_valid) begin
        r_rx_cnt <= r_rx_cnt + 4'd1;
        if (r_rx_cnt < 4'd14) begin
          r_rx_pay <= {r_rx_pay[103:0], bus.urx_data};
        end else if (r_rx_cnt == 4'd14) begin
          r_rx_crc_hi <= bus.urx_data;
        end else begin
          r_chk_pay <= r_rx_pay;
          r_chk_crc <= {r_rx_crc_hi, bus.urx_data};
        end
      end else if (w_timeout) begin
        r_rx_cnt <= '0;
      end

      // A fresh load wins over the grant so an overrun frame is still checked.
      if (w_rx_load) begin
        r_rx_req <= 1'b1;
      end else if (w_grant_rx) begin
        r_rx_req <= 1'b0;
      end

      r_rx_frame_valid <= w_grant_rx && w_crc_match;
      r_rx_crc_err     <= w_grant_rx && !w_crc_match;
      if (w_grant_rx && w_crc_match) begin
        r_rx_block <= r_chk_pay;
      end
    end
  end

  assign bus.rx_block       = r_rx_block;
  assign bus.rx_frame_valid = r_rx_frame_valid;
  assign bus.rx_crc_err     = r_rx_crc_err;

  assign w_tx_accept = (r_tx_state == TX_IDLE) && bus.tx_start;
  assign w_tx_hs     = (r_tx_state == TX_SEND) && bus.utx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_state_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (bus.tx_start) w_tx_state_nxt = TX_CRC;
      TX_CRC:  if (w_grant_tx) w_tx_state_nxt = TX_SEND;
      TX_SEND: if (bus.utx_ready && (r_tx_idx == 4'd15)) w_tx_state_nxt = TX_IDLE;
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_pay <= '0;
      r_tx_crc <= '0;
      r_tx_idx <= '0;
      r_tx_req <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_pay <= bus.tx_block;
      r_tx_req <= 1'b1;
    end else if (w_grant_tx) begin
      r_tx_crc <= bus.crc_in;
      r_tx_req <= 1'b0;
      r_tx_idx <= '0;
    end else if (w_tx_hs) begin
      r_tx_idx <= r_tx_idx + 4'd1;
    end
  end

  // Frame byte k sits at bits [127-8k -: 8] of {payload, crc}.
  assign w_tx_frame    = {r_tx_pay, r_tx_crc};
  assign w_tx_msb      = 7'd127 - {r_tx_idx, 3'b000};
  assign bus.tx_busy   = (r_tx_state != TX_IDLE);
  assign bus.utx_valid = (r_tx_state == TX_SEND);
  assign bus.utx_data  = (r_tx_state == TX_SEND) ? w_tx_frame[w_tx_msb -: 8] : 8'h00;

endmodule

// File: doc/crc_frame_ctrl.md
# crc_frame_ctrl

Frame controller and arbiter for the shared 112-bit CRC-16 unit (polynomial 1+x^2+x^15+x^16, zero initial value) on the UART link. It assembles 16-byte receive frames (14 payload bytes plus 2 CRC bytes) from the UART receiver and checks them. It also serialises 112-bit transmit blocks into 16-byte frames for the UART transmitter. The controller owns the only CRC instance: it drives that instance's `data_in`/`crc_en` and arbitrates between the RX-check and TX-generate requesters. It sits between the UART byte interfaces and the AES block datapath.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle clock cycles between RX bytes before a partial frame is discarded. Used only with `CRC_CTRL_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `urx_valid` in 1: one-cycle strobe for a received UART byte. No backpressure.
- `urx_data` in 8: received byte.
- `rx_block` out 112: payload of the last good frame. Held until the next good frame.
- `rx_frame_valid` out 1: one-cycle pulse for a good frame.
- `rx_crc_err` out 1: one-cycle pulse for a frame with a CRC mismatch.
- `tx_start` in 1: request to send `tx_block`. Accepted only when `tx_busy` = 0.
- `tx_block` in 112: payload to transmit. Sampled on accept.
- `tx_busy` out 1: TX frame in progress.
- `utx_valid` out 1: byte offered to the UART transmitter.
- `utx_data` out 8: byte to transmit.
- `utx_ready` in 1: transmitter accepts the byte when `utx_valid` & `utx_ready`.
- `crc_data` out 112: drives the CRC unit `data_in`.
- `crc_en` out 1: drives the CRC unit `crc_en`.
- `crc_in` in 16: CRC unit `crc_out`, which is combinational from `crc_data`/`crc_en`.

## Operation
- **Byte order**
  - Payload byte k (k = 0..13) maps to bits [111-8k : 104-8k]. The first byte is the MSB.
  - Byte 14 = crc[15:8]; byte 15 = crc[7:0].
- **RX assembly**
  - A 4-bit counter `rx_cnt` tracks the byte position and increments on every `urx_valid`.
  - On byte 15, {payload, crc} is copied into a check register and `rx_cnt` wraps to 0 in the same cycle. Back-to-back frames lose no bytes.
  - Copying into the check register raises `rx_req`.
- **TX FSM states**
  - TX_IDLE: `tx_start` captures `tx_block`, raises `tx_req` and goes to TX_CRC.
  - TX_CRC: waits for grant, captures `crc_in` into the CRC register, then goes to TX_SEND with byte index 0.
  - TX_SEND: offers byte[idx] and advances idx on each handshake. After the handshake on byte 15 it returns to TX_IDLE.
- **Arbiter**
  - One grant per cycle. `rx_req` has fixed priority over `tx_req`.
  - Granted requester: `crc_data` = its payload, `crc_en` = 1, and `crc_in` is sampled in the same cycle.
  - No grant: `crc_data` = 0, `crc_en` = 0.
- **RX check**
  - On grant, if `crc_in` == received CRC: `rx_block` is updated and `rx_frame_valid` pulses.
  - Otherwise `rx_crc_err` pulses and `rx_block` is unchanged.
- **Overrun**: if a new check-register load occurs while `rx_req` is still pending, the new frame overwrites the old one. The old frame produces no pulse.

## Timing
- **Reset values**: all outputs 0, `rx_cnt` = 0, TX FSM = TX_IDLE, `rx_req` = 0, `tx_req` = 0.
- **Reset mid-operation**: a partial RX frame and any in-flight TX frame are abandoned. `utx_valid` drops the cycle after `rst_n` is sampled low.
- **RX latency**: last CRC byte in cycle N → grant in N+1 → `rx_frame_valid`/`rx_crc_err` high in N+2 for exactly one cycle.
- **TX latency**: `tx_start` accepted in cycle N → `tx_busy` = 1 from N+1 → grant no earlier than N+1 → `utx_valid` for byte 0 at grant+1.
- **Simultaneous RX and TX requests**: TX is granted one cycle later. RX requests arrive at most once per 16 bytes, so TX cannot starve.
- **utx handshake**: `utx_valid`/`utx_data` stay stable until `utx_ready`. Consecutive bytes may be offered on consecutive cycles.
- **End of TX frame**: `tx_busy` falls in the cycle after the byte-15 handshake. `tx_start` is accepted again from that cycle.
- **`tx_start` while busy**: ignored.

## Configuration
- **`CRC_CTRL_TIMEOUT_EN` defined**
  - An idle counter resets on each `urx_valid`.
  - When it reaches `TIMEOUT_CYCLES` with `rx_cnt` ≠ 0, `rx_cnt` is cleared and the partial frame is discarded silently.
  - The counter saturates while `rx_cnt` = 0.
- **Undefined**: no timeout logic. A partial frame waits indefinitely.

## Test plan
- Send 16 bytes of 0x00 → `rx_frame_valid` pulse 2 cycles after the last byte, `rx_block` = 0, `rx_crc_err` = 0.
- Send 13×0x00, 0x01, 0x80, 0x05 → `rx_frame_valid`, `rx_block` = 112'h1. Repeat with last byte 0x04 → `rx_crc_err` pulse, `rx_block` stays 112'h1.
- `tx_block` = 112'h1, `utx_ready` = 1 → `utx_data` sequence 13×0x00, 0x01, 0x80, 0x05. `tx_busy` falls after byte 15. Repeat with `utx_ready` toggling every other cycle → same bytes, each held stable.
- Final RX byte and `tx_start` in the same cycle → RX granted first, TX one cycle later. Both results are correct.
- Pull `rst_n` low during TX byte 7 → all outputs 0 next cycle. A subsequent full frame is correct.
- With `CRC_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 20: send 5 bytes, idle 25 cycles, then send a valid 16-byte frame → exactly one `rx_frame_valid` with the correct payload.
